// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: pops commands from the command queue, picks a free PE
// round-robin, and hands the command over with a one-hot valid/ready
// handshake. A PE stays marked busy until it pulses its done line.
module cmd_dispatcher #(
  parameter int NUM_PE = 4,
  parameter int WIDTH  = 248,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_empty,
  input  logic [WIDTH-1:0]  i_fifo_data,
  output logic              o_fifo_read,
  output logic [NUM_PE-1:0] o_pe_valid,
  input  logic [NUM_PE-1:0] i_pe_ready,
  output logic [WIDTH-1:0]  o_pe_cmd,
  input  logic [NUM_PE-1:0] i_pe_done,
  output logic [NUM_PE-1:0] o_busy_mask,
  output logic [CNT_W-1:0]  o_issued,
  output logic              o_idle
);

  localparam int PTR_W = $clog2(NUM_PE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ARB   = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;

  logic [2:0]        state;
  logic [WIDTH-1:0]  cmd_reg;
  logic [NUM_PE-1:0] grant;
  logic [NUM_PE-1:0] busy;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_next;
  logic [NUM_PE-1:0] set_vec;
  logic [NUM_PE-1:0] hi_oh, lo_oh, arb_grant;
  logic              hi_hit, lo_hit, arb_hit;
  logic              hs;

  // Handshake only counts on the granted lane; stray readies are ignored.
  assign hs      = (state == S_ISSUE) && |(i_pe_ready & grant);
  assign set_vec = hs ? grant : '0;

  // Round-robin pick: first free PE at or above rr_ptr, else wrap to the
  // lowest free PE.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_oh  = '0;
    lo_oh  = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!busy[i]) begin
        if (!lo_hit) begin
          lo_hit   = 1'b1;
          lo_oh[i] = 1'b1;
        end
        if (!hi_hit && (PTR_W'(i) >= rr_ptr)) begin
          hi_hit   = 1'b1;
          hi_oh[i] = 1'b1;
        end
      end
    end
    arb_hit   = lo_hit;
    arb_grant = hi_hit ? hi_oh : lo_oh;
  end

  // Pointer advances to the lane just past the one being granted.
  always_comb begin
    rr_next = '0;
    for (int i = 0; i < NUM_PE; i++)
      if (grant[i]) rr_next = (i == NUM_PE - 1) ? '0 : PTR_W'(i + 1);
  end

  // Main sequencer: IDLE -> POP -> LOAD -> ARB -> ISSUE -> IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cmd_reg  <= '0;
      grant    <= '0;
      rr_ptr   <= '0;
      o_issued <= '0;
    end else begin
      case (state)
        S_IDLE:  if (!i_fifo_empty) state <= S_POP;
        S_POP:   state <= S_LOAD;
        S_LOAD: begin
          cmd_reg <= i_fifo_data;
          state   <= S_ARB;
        end
        S_ARB: if (arb_hit) begin
          grant <= arb_grant;
          state <= S_ISSUE;
        end
        S_ISSUE: if (hs) begin
          rr_ptr   <= rr_next;
          o_issued <= o_issued + CNT_W'(1);
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Busy tracking: done clears, issue sets; set wins on the same lane.
  always_ff @(posedge i_clk) begin
    if (i_rst) busy <= '0;
    else       busy <= (busy & ~i_pe_done) | set_vec;
  end

  assign o_fifo_read = (state == S_POP);
  assign o_pe_valid  = (state == S_ISSUE) ? grant : '0;
  assign o_pe_cmd    = cmd_reg;
  assign o_busy_mask = busy;
  assign o_idle      = (state == S_IDLE) && i_fifo_empty && (busy == '0);

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Consumer end of the command queue. Pops `cmd_t` entries from the queue FIFO, arbitrates round-robin among free processing elements (PEs), and delivers each command over a one-hot valid/ready handshake. Tracks per-PE busy state until each PE signals completion. Sits between `cmd_queue` and the SIMD PE array.

## Interface
- `NUM_PE`, 4: number of processing elements (2..8).
- `WIDTH`, 248: command width, equal to `$bits(cmd_t)`.
- `CNT_W`, 16: width of the issued-command counter.

- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_fifo_empty` in 1: queue empty flag.
- `i_fifo_data` in WIDTH (`cmd_t`): queue read data.
- `o_fifo_read` out 1: queue pop strobe.
- `o_pe_valid` out NUM_PE: one-hot command valid.
- `i_pe_ready` in NUM_PE: per-PE accept.
- `o_pe_cmd` out WIDTH: command broadcast to all PEs.
- `i_pe_done` in NUM_PE: per-PE single-cycle completion pulse.
- `o_busy_mask` out NUM_PE: registered busy bits.
- `o_issued` out CNT_W: count of accepted commands.
- `o_idle` out 1: `state==IDLE && i_fifo_empty && busy_mask==0`.

## Operation
- **FSM states:** IDLE, POP, LOAD, ARB, ISSUE.
- **IDLE:** moves to POP when `!i_fifo_empty`. Otherwise stays.
- **POP:** `o_fifo_read=1` for exactly this one cycle, then moves to LOAD. `o_fifo_read` is 0 in every other state.
- **LOAD:** the queue read data is valid one cycle after the pop. `i_fifo_data` is captured into `cmd_reg`, then the FSM moves to ARB. `o_pe_cmd = cmd_reg` at all times.
- **ARB:** search the free PEs (`~busy_mask`) starting at index `rr_ptr` and wrapping modulo NUM_PE. The first hit is latched into `grant` (one-hot) and the FSM moves to ISSUE. With no free PE, ARB holds and `o_pe_valid=0`.
- **ISSUE:** `o_pe_valid=grant`. `grant` and `o_pe_cmd` stay stable until `i_pe_ready & grant` is nonzero. Ready bits from non-granted PEs are ignored.
- **Handshake cycle:**
  - set `busy[k]`
  - `rr_ptr <= (k+1) mod NUM_PE`
  - increment `o_issued`, wrapping from 2^CNT_W−1 to 0
  - return to IDLE
- **Done handling:** `i_pe_done[k]` clears `busy[k]` at the next edge in any state. Done on a non-busy PE is ignored.
- **Done and issue on the same PE in the same cycle:** cannot be legal, since a granted PE is not busy. The set wins.
- **Done on PE j while issuing to PE k≠j:** both take effect.
- **Multiple simultaneous done bits:** all are cleared.
- **Reset (any state, including mid-ISSUE):**
  - state=IDLE, `cmd_reg` and `grant` cleared; any in-flight command is dropped and not re-queued
  - `busy_mask=0`, `rr_ptr=0`, `o_issued=0`
  - `o_fifo_read=0`, `o_pe_valid=0`
  - `o_idle` = `i_fifo_empty`

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from `i_pe_ready` or `i_pe_done` to any output.
- **Queue to PE latency:** IDLE sees non-empty at edge 0 → POP in cycle 1 → LOAD in cycle 2 → ARB in cycle 3 → `o_pe_valid` high in cycle 4 if a PE is free.
- **Best-case throughput:** one command per 5 cycles (IDLE→POP→LOAD→ARB→ISSUE with ready=1).
- **Busy visibility:** a done pulse at edge t makes the PE eligible in an ARB evaluated after t.
- **Empty queue:** the FIFO is never read while `i_fifo_empty=1`, because the flag is checked only in IDLE.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles with the queue non-empty → `o_fifo_read=0`, `o_pe_valid=0`, `o_busy_mask=0`, `o_issued=0`. The first pop occurs in the second cycle after release.
- **Single command:** load 0xA5…A5, NUM_PE=4, all ready=1 → `o_pe_valid=4'b0001` in cycle 4 with `o_pe_cmd=0xA5…A5`. Then `o_busy_mask=4'b0001`, `o_issued=1`.
- **Round-robin:** 5 commands, ready=1, no done → grants 0001, 0010, 0100, 1000. The fifth command holds in ARB with `o_pe_valid=0`. A done pulse on PE2 → the fifth command is granted 0100.
- **Back-pressure:** ready low for 7 cycles → valid, grant and cmd stable for 7 cycles. Acceptance on cycle 8 with `o_issued` incremented by exactly 1.
- **Simultaneous events:** done on PE0 during the handshake to PE1 → busy goes from 0001 to 0010. Stray done on idle PE3 → no change. Counter preloaded to 0xFFFF plus one issue → 0x0000.
- **Reset mid-ISSUE:** reset while `o_pe_valid=0010` → all state cleared, and the command does not reappear.
